// File: rtl/mole_game_ctrl_if.sv
// Signal bundle between the whack-a-mole round sequencer and its surroundings.
// EN is a level; tick is a one-cycle enable pulse; button_j is a debounced level; all outputs are registered.
interface mole_game_ctrl_if;
  logic       EN;
  logic       tick;
  logic [2:0] rnd;
  logic [7:0] button_j;
  logic [7:0] LEDs;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;
  logic       hit_p;
  logic       miss_p;
  logic [2:0] state_dbg;

  modport master (
    output EN, tick, rnd, button_j,
    input  LEDs, score, misses, game_over, hit_p, miss_p, state_dbg
  );

  modport slave (
    input  EN, tick, rnd, button_j,
    output LEDs, score, misses, game_over, hit_p, miss_p, state_dbg
  );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: spawns moles from rnd, times the up window on ticks,
// judges button rises, and keeps score, misses and a shrinking up window.
module mole_game_ctrl #(
  parameter int TIMEOUT_TICKS = 800,
  parameter int GAP_TICKS     = 200,
  parameter int MIN_TIMEOUT   = 300,
  parameter int STEP_TICKS    = 50,
  parameter int HITS_PER_STEP = 8,
  parameter int MAX_MISS      = 5
) (
  input  logic            Clk,
  input  logic            reset,
  mole_game_ctrl_if.slave bus
);
  localparam int CW = 16;
  localparam int HW = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0] GAP_C      = CW'(GAP_TICKS);
  localparam logic [CW-1:0] MIN_C      = CW'(MIN_TIMEOUT);
  localparam logic [CW-1:0] STEP_C     = CW'(STEP_TICKS);
  localparam logic [HW-1:0] HIT_LAST_C = HW'(HITS_PER_STEP - 1);
  localparam logic [3:0]    MAX_MISS_C = 4'(MAX_MISS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_SPAWN = 3'd2,
    S_UP    = 3'd3,
    S_HIT   = 3'd4,
    S_MISS  = 3'd5,
    S_OVER  = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic          en_q;
  logic [7:0]    btn_q;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] up_q, up_d;
  logic [CW-1:0] window_q, window_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [2:0]    last_idx_q, last_idx_d;
  logic [7:0]    leds_q, leds_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    misses_q, misses_d;
  logic          over_q, over_d;
  logic          hit_p_q, hit_p_d;
  logic          miss_p_q, miss_p_d;

  logic          start;
  logic [7:0]    rise;
  logic [2:0]    spawn_idx;
  logic          gap_last;
  logic          up_last;
  logic [3:0]    misses_inc;

  assign start      = bus.EN & ~en_q;
  assign rise       = bus.button_j & ~btn_q;
  // Never light the same mole twice in a row.
  assign spawn_idx  = (bus.rnd == last_idx_q) ? bus.rnd + 3'd1 : bus.rnd;
  assign gap_last   = bus.tick && (gap_q <= CW'(1));
  assign up_last    = bus.tick && (up_q <= CW'(1));
  assign misses_inc = misses_q + 4'd1;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.EN) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: if (start) state_d = S_GAP;
        S_GAP:          if (gap_last) state_d = S_SPAWN;
        S_SPAWN:        state_d = S_UP;
        S_UP: begin
          // A correct rise beats both a wrong bit rising alongside it and the final tick.
          if (rise != 8'h00)  state_d = rise[last_idx_q] ? S_HIT : S_MISS;
          else if (up_last)   state_d = S_MISS;
        end
        S_HIT:          state_d = S_GAP;
        S_MISS:         state_d = (misses_inc == MAX_MISS_C) ? S_OVER : S_GAP;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    gap_d      = gap_q;
    up_d       = up_q;
    window_d   = window_q;
    hits_d     = hits_q;
    last_idx_d = last_idx_q;
    leds_d     = 8'h00;
    score_d    = score_q;
    misses_d   = misses_q;
    over_d     = over_q;
    hit_p_d    = 1'b0;
    miss_p_d   = 1'b0;
    if (bus.EN) begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            score_d  = 8'h00;
            misses_d = 4'h0;
            over_d   = 1'b0;
            hits_d   = '0;
            window_d = TIMEOUT_C;
            gap_d    = GAP_C;
          end
        end
        S_GAP: begin
          if (bus.tick && gap_q != '0) gap_d = gap_q - CW'(1);
        end
        S_SPAWN: begin
          last_idx_d = spawn_idx;
          leds_d     = 8'h01 << spawn_idx;
          up_d       = window_q;
        end
        S_UP: begin
          leds_d = leds_q;
          if (rise == 8'h00 && bus.tick && up_q != '0) up_d = up_q - CW'(1);
        end
        S_HIT: begin
          hit_p_d = 1'b1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          gap_d = GAP_C;
          if (hits_q == HIT_LAST_C) begin
            hits_d   = '0;
            window_d = ((window_q >= STEP_C) && (window_q - STEP_C >= MIN_C)) ?
                       window_q - STEP_C : MIN_C;
          end else begin
            hits_d = hits_q + HW'(1);
          end
        end
        S_MISS: begin
          miss_p_d = 1'b1;
          misses_d = misses_inc;
          if (misses_inc == MAX_MISS_C) over_d = 1'b1;
          else                          gap_d  = GAP_C;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      btn_q      <= 8'h00;
      gap_q      <= '0;
      up_q       <= '0;
      window_q   <= TIMEOUT_C;
      hits_q     <= '0;
      last_idx_q <= 3'd0;
      leds_q     <= 8'h00;
      score_q    <= 8'h00;
      misses_q   <= 4'h0;
      over_q     <= 1'b0;
      hit_p_q    <= 1'b0;
      miss_p_q   <= 1'b0;
    end else begin
      en_q       <= bus.EN;
      btn_q      <= bus.button_j;
      gap_q      <= gap_d;
      up_q       <= up_d;
      window_q   <= window_d;
      hits_q     <= hits_d;
      last_idx_q <= last_idx_d;
      leds_q     <= leds_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      over_q     <= over_d;
      hit_p_q    <= hit_p_d;
      miss_p_q   <= miss_p_d;
    end
  end

  assign bus.LEDs      = leds_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = over_q;
  assign bus.hit_p     = hit_p_q;
  assign bus.miss_p    = miss_p_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomized bench for mole_game_ctrl: plays whole games against a mole-level model
// (expected index, window length, score, misses) and compares at every cycle.
module tb_mole_game_ctrl;
  localparam int TO  = 10;
  localparam int GP  = 2;
  localparam int MN  = 4;
  localparam int ST  = 3;
  localparam int HPS = 4;
  localparam int MM  = 3;

  logic Clk;
  logic reset;
  mole_game_ctrl_if bus ();

  mole_game_ctrl #(
    .TIMEOUT_TICKS(TO), .GAP_TICKS(GP), .MIN_TIMEOUT(MN),
    .STEP_TICKS(ST), .HITS_PER_STEP(HPS), .MAX_MISS(MM)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state
  int m_score, m_misses, m_hits, m_window, m_last;
  bit m_over;
  int n_checks, n_errors;
  int idle_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rtick();
    bit t;
    t = ($urandom_range(0, 1) == 1) || (idle_run >= 3);
    idle_run = t ? 0 : idle_run + 1;
    return t;
  endfunction

  function automatic int pred_idx(input int r);
    return (r == m_last) ? (r + 1) % 8 : r;
  endfunction

  task automatic model_new_game();
    m_score  = 0;
    m_misses = 0;
    m_hits   = 0;
    m_window = TO;
    m_over   = 0;
  endtask

  // Driver: apply inputs for one edge, then sample just after it.
  task automatic cyc(input bit t, input logic [7:0] b);
    bus.tick     = t;
    bus.button_j = b;
    @(posedge Clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic start_game();
    bus.EN = 1'b0;
    cyc(1'b0, 8'h00);
    check("en_low_led", bus.LEDs, 0);
    check("en_low_score", bus.score, m_score);
    check("en_low_misses", bus.misses, m_misses);
    check("en_low_over", bus.game_over, m_over);
    bus.EN = 1'b1;
    cyc(1'b0, 8'h00);
    model_new_game();
    check("start_score", bus.score, 0);
    check("start_misses", bus.misses, 0);
    check("start_over", bus.game_over, 0);
    check("start_led", bus.LEDs, 0);
  endtask

  task automatic gap_and_spawn(input int r, input logic [7:0] hold, output int idx);
    int ticks;
    bit t;
    logic [7:0] noise;
    bus.rnd = 3'(r);
    ticks = 0;
    for (int c = 0; ticks < GP && c < 100; c++) begin
      t = rtick();
      noise = ($urandom_range(0, 3) == 0) ? 8'($urandom) : hold;
      cyc(t, noise);
      if (t) ticks++;
      check("gap_led", bus.LEDs, 0);
      check("gap_pulse", {bus.hit_p, bus.miss_p}, 0);
    end
    cyc(1'b0, hold);
    idx = pred_idx(r);
    m_last = idx;
    check("spawn_led", bus.LEDs, 32'd1 << idx);
  endtask

  task automatic up_wait(input int idx, input logic [7:0] hold, input int n, output int ticks);
    bit t;
    ticks = 0;
    for (int c = 0; c < n; c++) begin
      t = (ticks < m_window - 1) ? rtick() : 1'b0;
      cyc(t, hold);
      if (t) ticks++;
      check("up_led", bus.LEDs, 32'd1 << idx);
      check("up_pulse", {bus.hit_p, bus.miss_p}, 0);
    end
  endtask

  task automatic miss_outcome();
    m_misses++;
    if (m_misses == MM) m_over = 1;
    check("miss_p", {bus.hit_p, bus.miss_p}, 2'b01);
    check("miss_count", bus.misses, m_misses);
    check("miss_over", bus.game_over, m_over);
    check("miss_led_off", bus.LEDs, 0);
    check("miss_score", bus.score, m_score);
  endtask

  task automatic do_hit(input int idx, input logic [7:0] hold, input int min_wait, input bit extra);
    int ticks;
    bit t;
    logic [7:0] press;
    up_wait(idx, hold, $urandom_range(min_wait, min_wait + 4), ticks);
    // Any tick here is at most the final one, so a coincident timeout is exercised too.
    t = 1'($urandom_range(0, 1));
    press = hold | (8'h01 << idx) | (extra ? (8'($urandom) & ~hold) : 8'h00);
    cyc(t, press);
    check("hit_led_held", bus.LEDs, 32'd1 << idx);
    check("hit_pulse_early", {bus.hit_p, bus.miss_p}, 0);
    cyc(1'b0, press);
    m_score = (m_score < 255) ? m_score + 1 : 255;
    m_hits++;
    if (m_hits % HPS == 0) m_window = (m_window - ST < MN) ? MN : m_window - ST;
    check("hit_p", {bus.hit_p, bus.miss_p}, 2'b10);
    check("hit_score", bus.score, m_score);
    check("hit_led_off", bus.LEDs, 0);
    check("hit_misses", bus.misses, m_misses);
  endtask

  task automatic do_wrong(input int idx, input logic [7:0] hold, input int w);
    int ticks;
    bit t;
    logic [7:0] press;
    up_wait(idx, hold, $urandom_range(0, 3), ticks);
    t = 1'($urandom_range(0, 1));
    press = hold | (8'h01 << w);
    cyc(t, press);
    check("wrong_led_held", bus.LEDs, 32'd1 << idx);
    check("wrong_pulse_early", {bus.hit_p, bus.miss_p}, 0);
    cyc(1'b0, press);
    miss_outcome();
  endtask

  task automatic do_timeout(input int idx, input logic [7:0] hold);
    int ticks;
    bit t;
    ticks = 0;
    for (int c = 0; c < 400 && ticks < m_window; c++) begin
      t = rtick();
      cyc(t, hold);
      if (t) ticks++;
      check("to_led", bus.LEDs, 32'd1 << idx);
      check("to_pulse", {bus.hit_p, bus.miss_p}, 0);
    end
    cyc(1'b0, hold);
    miss_outcome();
  endtask

  task automatic check_over_hold();
    for (int c = 0; c < 6; c++) begin
      cyc(rtick(), 8'($urandom));
      check("over_led", bus.LEDs, 0);
      check("over_flag", bus.game_over, 1);
      check("over_pulse", {bus.hit_p, bus.miss_p}, 0);
      check("over_score", bus.score, m_score);
    end
  endtask

  task automatic play_random_game(input int max_moles);
    int idx, a;
    start_game();
    for (int m = 0; m < max_moles && !m_over; m++) begin
      gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
      a = $urandom_range(0, 9);
      if (a < 7)      do_hit(idx, 8'h00, 0, a < 2);
      else if (a < 9) do_wrong(idx, 8'h00, (idx + $urandom_range(1, 7)) % 8);
      else            do_timeout(idx, 8'h00);
    end
    if (m_over) check_over_hold();
  endtask

  initial begin
    int idx, idx2, w, r, ticks;
    logic [7:0] hold;
    n_checks = 0;
    n_errors = 0;
    idle_run = 0;
    m_last   = 0;
    model_new_game();
    reset        = 1'b0;
    bus.EN       = 1'b0;
    bus.tick     = 1'b0;
    bus.rnd      = 3'd0;
    bus.button_j = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_led", bus.LEDs, 0);
    check("rst_score", bus.score, 0);
    check("rst_misses", bus.misses, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_pulse", {bus.hit_p, bus.miss_p}, 0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 8'h00);
      check("idle_led", bus.LEDs, 0);
    end

    // rnd stuck at 4 alternates 4,5,4,5
    start_game();
    for (int i = 0; i < 4; i++) begin
      gap_and_spawn(4, 8'h00, idx);
      check("stuck_led", bus.LEDs, (i % 2 == 0) ? 32'h10 : 32'h20);
      do_hit(idx, 8'h00, 0, 1'b0);
    end

    // Wrong button held through the next mole never re-triggers
    gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
    w = (idx + $urandom_range(1, 7)) % 8;
    do_wrong(idx, 8'h00, w);
    hold = 8'h01 << w;
    r = $urandom_range(0, 7);
    for (int k = 0; k < 16 && pred_idx(r) == w; k++) r = (r + 1) % 8;
    gap_and_spawn(r, hold, idx2);
    do_hit(idx2, hold, 3, 1'b0);

    // EN drop while a mole is up
    gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
    up_wait(idx, 8'h00, 2, ticks);
    start_game();

    // Asynchronous reset while a mole is up
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 7);
      for (int k = 0; k < 16 && pred_idx(r) == 4; k++) r = (r + 1) % 8;
      gap_and_spawn(r, 8'h00, idx);
      do_hit(idx, 8'h00, 0, 1'b0);
    end
    gap_and_spawn(4, 8'h00, idx);
    check("pre_rst_led", bus.LEDs, 32'h10);
    check("pre_rst_score", bus.score, 3);
    bus.EN = 1'b0;
    reset  = 1'b0;
    #1;
    check("arst_led", bus.LEDs, 0);
    check("arst_score", bus.score, 0);
    check("arst_misses", bus.misses, 0);
    check("arst_over", bus.game_over, 0);
    check("arst_pulse", {bus.hit_p, bus.miss_p}, 0);
    repeat (2) @(posedge Clk);
    #1;
    reset  = 1'b1;
    m_last = 0;
    model_new_game();
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 8'h00);
      check("post_rst_led", bus.LEDs, 0);
    end

    for (int g = 0; g < 4; g++) play_random_game(15);

    // Window shrink, floor, score saturation, then game over and restart
    start_game();
    for (int i = 0; i < 4; i++) begin
      gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
      do_hit(idx, 8'h00, 0, 1'b0);
    end
    gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
    do_timeout(idx, 8'h00);
    for (int i = 0; i < 256; i++) begin
      gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
      do_hit(idx, 8'h00, 0, 1'b0);
    end
    check("sat_score", bus.score, 255);
    gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
    do_timeout(idx, 8'h00);
    gap_and_spawn($urandom_range(0, 7), 8'h00, idx);
    do_timeout(idx, 8'h00);
    check("final_over", bus.game_over, 1);
    check_over_hold();
    start_game();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Round sequencer for the whack-a-mole game.
- Picks which mole LED lights from the random-index source and times each mole's up window with a 1 ms tick enable.
- Judges debounced button presses against the lit mole; keeps score, miss count and difficulty.
- Drives the mole LEDs and the binary score that feeds the BCD/7-segment display path. Ends the game after a configured number of misses.

Parameters:
- TIMEOUT_TICKS, 800, initial mole up-window in ticks
- GAP_TICKS, 200, all-off gap between moles in ticks
- MIN_TIMEOUT, 300, floor for the up-window
- STEP_TICKS, 50, up-window reduction per speed-up
- HITS_PER_STEP, 8, hits between speed-ups (power of 2)
- MAX_MISS, 5, misses that end the game (1..15)

Ports:
- Clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- EN  input  1  game enable, level; rising edge starts a game
- tick  input  1  1-cycle 1 ms enable pulse
- rnd  input  3  random mole index, sampled at spawn
- button_j  input  8  debounced buttons, active-high level
- LEDs  output  8  one-hot mole, active-high
- score  output  8  hits this game, saturating
- misses  output  4  misses this game
- game_over  output  1  high in OVER state
- hit_p  output  1  1-cycle pulse per hit
- miss_p  output  1  1-cycle pulse per miss

Behaviour:
- Reset (reset=0, async):
  - State IDLE; LEDs=0, score=0, misses=0, game_over=0, hit_p=0, miss_p=0.
  - Internal: window=TIMEOUT_TICKS, last_idx=0, en_q=0, btn_q=0, counters 0.
- Edge detection:
  - en_q, btn_q registered every cycle.
  - start = EN & ~en_q.
  - rise = button_j & ~btn_q.
  - Held buttons never re-trigger.
- EN=0 in any state: next cycle to IDLE, LEDs=0; score/misses/game_over hold.
- IDLE: LEDs=0. On start:
  - clear score, misses, game_over, hit counter;
  - window=TIMEOUT_TICKS;
  - load gap counter=GAP_TICKS; go GAP.
- OVER: game_over=1, LEDs=0. Leaves only via start (EN must drop and rise again), with the same clearing as IDLE.
- GAP:
  - LEDs=0; decrement gap counter on tick; rise ignored.
  - On the tick that takes the counter to 0, go SPAWN.
- SPAWN (1 cycle):
  - idx = rnd, or (rnd+1) mod 8 if rnd==last_idx (no immediate repeat).
  - last_idx=idx; LEDs=1<<idx; up counter=window; go UP.
- UP (LEDs held):
  - If rise!=0 and rise[idx]=1: go HIT, even if other bits also rose.
  - If rise!=0 and rise[idx]=0: go MISS (wrong button).
  - Else, on tick: decrement up counter; at 0 go MISS (timeout).
  - Same cycle correct rise and final tick: HIT wins.
- HIT (1 cycle):
  - LEDs=0; hit_p=1; score+1, saturating at 255; hit counter+1.
  - When hit counter reaches HITS_PER_STEP (wraps to 0): window = max(window-STEP_TICKS, MIN_TIMEOUT), no underflow.
  - Reload gap counter; go GAP.
- MISS (1 cycle):
  - LEDs=0; miss_p=1; misses+1.
  - If new misses==MAX_MISS, go OVER; else reload gap counter, go GAP.
- Latency: rise sampled in UP at edge N → HIT/MISS state after edge N; score/misses/pulses visible after edge N+1.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-UP (LEDs=8'h10, score=3) → all outputs 0 immediately; IDLE after release; no LED until a new EN rise.
- EN rise, GAP_TICKS=2, rnd=5, press button 5 three cycles after spawn → LEDs=8'h20, then hit_p one cycle, score=1, LEDs=0, new spawn after 2 ticks.
- No press, TIMEOUT_TICKS=3 → miss_p on the 3rd tick in UP, misses=1; MAX_MISS=2 and repeat → game_over=1, LEDs=0; hold EN=1 → stays OVER; EN 0→1 → score=0, misses=0.
- Wrong button (mole 2, press 6) → miss_p; button 6 held through the next mole → no further miss.
- rnd stuck at 4 → consecutive moles on indices 4, 5, 4, 5.
- 8 hits with TIMEOUT_TICKS=800, STEP_TICKS=50 → window 750; repeat to floor 300 and it stays; 256 hits → score holds at 255.
